// File: rtl/riscv_defs.sv
// Shared RV32I definitions: load/store funct3 codes, LSU state encoding, request classifiers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package riscv_defs;

   localparam int XLEN_C = 32;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } lsu_state_t;

   // Codes that have no RV32I meaning for the given direction.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic r;
      if (we) begin
         r = !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
      end else begin
         r = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return r;
   endfunction

   // Size lives in funct3[1:0] for every legal code: 00 byte, 01 half, 10 word.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic r;
      case (f3[1:0])
         2'b01:   r = a[0];
         2'b10:   r = (a != 2'b00);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for stores on a 32-bit memory word.
// Latency: purely combinational.
// Backpressure: none; the FSM decides when results are used.
module lsu_align
   import riscv_defs::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_load_word,
   input  logic [31:0] i_old_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword out of the loaded word.
   always_comb begin
      w_byte = 8'h00;
      case (i_lane)
         2'd0:    w_byte = i_load_word[7:0];
         2'd1:    w_byte = i_load_word[15:8];
         2'd2:    w_byte = i_load_word[23:16];
         default: w_byte = i_load_word[31:24];
      endcase
      w_half = i_lane[1] ? i_load_word[31:16] : i_load_word[15:0];
   end

   // Sign- or zero-extend to the full register width.
   always_comb begin
      o_load_data = 32'h0;
      case (i_funct3)
         F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
         F3_LW:   o_load_data = i_load_word;
         F3_LBU:  o_load_data = {24'h0, w_byte};
         F3_LHU:  o_load_data = {16'h0, w_half};
         default: o_load_data = 32'h0;
      endcase
   end

   // Merge the store data into the old word; SW ignores the old word entirely.
   always_comb begin
      o_store_data = i_old_word;
      case (i_funct3)
         F3_SB: begin
            case (i_lane)
               2'd0:    o_store_data[7:0]   = i_wdata[7:0];
               2'd1:    o_store_data[15:8]  = i_wdata[7:0];
               2'd2:    o_store_data[23:16] = i_wdata[7:0];
               default: o_store_data[31:24] = i_wdata[7:0];
            endcase
         end
         F3_SH: begin
            if (i_lane[1]) begin
               o_store_data[31:16] = i_wdata[15:0];
            end else begin
               o_store_data[15:0]  = i_wdata[15:0];
            end
         end
         F3_SW:   o_store_data = i_wdata;
         default: o_store_data = i_old_word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time, sub-word stores as read-modify-write.
// Latency: error 1, load/SW 2, SB/SH 3 cycles from acceptance to the response pulse.
// Backpressure: req_ready only in IDLE; the response is a single pulse with no stall.
module lsu_ctrl
   import riscv_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_is_load,
   output logic            mem_is_store,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_store_data,
   input  logic [XLEN-1:0] mem_load_data
);

   lsu_state_t      r_state;
   lsu_state_t      w_next;

   logic            r_we;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_old;
   logic [XLEN-1:0] r_rdata;
   logic            r_err;

   logic            w_bad;
   logic [XLEN-1:0] w_word_addr;
   logic [XLEN-1:0] w_load_data;
   logic [XLEN-1:0] w_store_data;

   // Classification is done on the incoming request so the first state after
   // acceptance is already the right one; the same verdict is latched into r_err.
   assign w_bad       = f3_illegal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
   assign w_word_addr = {r_addr[XLEN-1:2], 2'b00};

   lsu_align u_align (
      .i_funct3     (r_funct3),
      .i_lane       (r_addr[1:0]),
      .i_load_word  (mem_load_data),
      .i_old_word   (r_old),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_data (w_store_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and all outputs; everything is forced quiet while reset
   // is held so a reset landing in WRITE cannot commit the store.
   always_comb begin
      w_next         = r_state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      mem_is_load    = 1'b0;
      mem_is_store   = 1'b0;
      mem_addr       = '0;
      mem_store_data = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_bad) begin
                  w_next = ST_RESP;
               end else if (!req_we) begin
                  w_next = ST_LOAD;
               end else if (req_funct3 == F3_SW) begin
                  w_next = ST_WRITE;
               end else begin
                  w_next = ST_RMW_RD;
               end
            end
         end
         ST_LOAD: begin
            mem_is_load = 1'b1;
            mem_addr    = w_word_addr;
            w_next      = ST_RESP;
         end
         ST_RMW_RD: begin
            mem_is_load = 1'b1;
            mem_addr    = w_word_addr;
            w_next      = ST_WRITE;
         end
         ST_WRITE: begin
            mem_is_store   = 1'b1;
            mem_addr       = w_word_addr;
            mem_store_data = w_store_data;
            w_next         = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_we ? '0 : r_rdata;
            resp_err   = r_err;
            w_next     = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (!rst_n) begin
         req_ready      = 1'b0;
         resp_valid     = 1'b0;
         resp_rdata     = '0;
         resp_err       = 1'b0;
         mem_is_load    = 1'b0;
         mem_is_store   = 1'b0;
         mem_addr       = '0;
         mem_store_data = '0;
      end
   end

   // Request capture, old-word capture for RMW, and the registered load result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_old    <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_err    <= w_bad;
                  r_rdata  <= '0;
               end
            end
            ST_LOAD: begin
               r_rdata <= w_load_data;
            end
            ST_RMW_RD: begin
               r_old <= mem_load_data;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word memory model and a vector table.
// Latency: checks response latency per request class.
// Backpressure: n/a.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_is_load;
   logic        mem_is_store;
   logic [31:0] mem_addr;
   logic [31:0] mem_store_data;
   logic [31:0] mem_load_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];
   logic        tb_wr;
   logic [7:0]  tb_widx;
   logic [31:0] tb_wdat;

   lsu_ctrl #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_is_load    (mem_is_load),
      .mem_is_store   (mem_is_store),
      .mem_addr       (mem_addr),
      .mem_store_data (mem_store_data),
      .mem_load_data  (mem_load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: combinational read, write on the rising edge.
   assign mem_load_data = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (tb_wr) begin
         mem[tb_widx] <= tb_wdat;
      end else if (mem_is_store) begin
         mem[mem_addr[9:2]] <= mem_store_data;
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_ld;
      int          exp_st;
      logic [31:0] exp_sdata;
   } vec_t;

   vec_t vt [0:25];

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                               input int lat, input int ld, input int st, input logic [31:0] sd);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat;
      v.exp_ld = ld; v.exp_st = st; v.exp_sdata = sd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one request, follow it to its response, and check the memory traffic.
   task automatic run_req(input vec_t v, input int idx);
      int          lat;
      int          nld;
      int          nst;
      logic        got;
      logic [31:0] rd;
      logic        er;
      logic [31:0] sd;
      logic [31:0] sa;
      logic [31:0] la;
      @(negedge clk);
      chk($sformatf("v%0d ready_before", idx), {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~v.we;
      req_funct3 = 3'b110;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'hA5A5_A5A5;
      lat = 0; nld = 0; nst = 0; got = 1'b0;
      rd = '0; er = 1'b0; sd = '0; sa = '0; la = '0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (mem_is_load) begin
            nld++;
            la = mem_addr;
         end
         if (mem_is_store) begin
            nst++;
            sd = mem_store_data;
            sa = mem_addr;
         end
         if (resp_valid) begin
            got = 1'b1;
            rd  = resp_rdata;
            er  = resp_err;
         end
      end
      chk($sformatf("v%0d resp_seen", idx), {31'h0, got}, 32'h1);
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
      chk($sformatf("v%0d err", idx), {31'h0, er}, {31'h0, v.exp_err});
      chk($sformatf("v%0d load_cycles", idx), nld, v.exp_ld);
      chk($sformatf("v%0d store_cycles", idx), nst, v.exp_st);
      if (v.exp_ld > 0) begin
         chk($sformatf("v%0d load_addr", idx), la, {v.addr[31:2], 2'b00});
      end
      if (v.exp_st > 0) begin
         chk($sformatf("v%0d store_data", idx), sd, v.exp_sdata);
         chk($sformatf("v%0d store_addr", idx), sa, {v.addr[31:2], 2'b00});
      end
      @(negedge clk);
      chk($sformatf("v%0d resp_one_cycle", idx), {31'h0, resp_valid}, 32'h0);
      chk($sformatf("v%0d ready_after", idx), {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      // Loads on 0xDEADBEEF at 0x40
      vt[0]  = mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0);
      vt[1]  = mk(1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0);
      vt[2]  = mk(1'b0, 3'b100, 32'h43, 32'h0, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0);
      vt[3]  = mk(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0);
      vt[4]  = mk(1'b0, 3'b101, 32'h40, 32'h0, 32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0);
      vt[5]  = mk(1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0);
      vt[6]  = mk(1'b0, 3'b100, 32'h41, 32'h0, 32'h000000BE, 1'b0, 2, 1, 0, 32'h0);
      vt[7]  = mk(1'b0, 3'b101, 32'h42, 32'h0, 32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0);
      // Sub-word and word stores, each followed by a readback
      vt[8]  = mk(1'b1, 3'b000, 32'h41, 32'h12, 32'h0, 1'b0, 3, 1, 1, 32'hDEAD12EF);
      vt[9]  = mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEAD12EF, 1'b0, 2, 1, 0, 32'h0);
      vt[10] = mk(1'b1, 3'b001, 32'h42, 32'hCAFE, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE12EF);
      vt[11] = mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE12EF, 1'b0, 2, 1, 0, 32'h0);
      vt[12] = mk(1'b1, 3'b010, 32'h44, 32'h01234567, 32'h0, 1'b0, 2, 0, 1, 32'h01234567);
      vt[13] = mk(1'b0, 3'b010, 32'h44, 32'h0, 32'h01234567, 1'b0, 2, 1, 0, 32'h0);
      vt[14] = mk(1'b1, 3'b000, 32'h47, 32'hABCDEF99, 32'h0, 1'b0, 3, 1, 1, 32'h99234567);
      vt[15] = mk(1'b1, 3'b001, 32'h44, 32'h5555BEEF, 32'h0, 1'b0, 3, 1, 1, 32'h9923BEEF);
      vt[16] = mk(1'b0, 3'b001, 32'h44, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0);
      vt[17] = mk(1'b0, 3'b000, 32'h46, 32'h0, 32'h00000023, 1'b0, 2, 1, 0, 32'h0);
      // Misaligned and illegal requests
      vt[18] = mk(1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[19] = mk(1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[20] = mk(1'b0, 3'b111, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[21] = mk(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[22] = mk(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[23] = mk(1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[24] = mk(1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
      vt[25] = mk(1'b1, 3'b010, 32'h42, 32'h77, 32'h0, 1'b1, 1, 0, 0, 32'h0);

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      tb_wr      = 1'b1;
      tb_widx    = 8'h10;
      tb_wdat    = 32'hDEADBEEF;

      // Reset values while reset is held
      repeat (3) @(negedge clk);
      tb_wr = 1'b0;
      chk("rst req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst resp_err", {31'h0, resp_err}, 32'h0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst mem_is_load", {31'h0, mem_is_load}, 32'h0);
      chk("rst mem_is_store", {31'h0, mem_is_store}, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_store_data", mem_store_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle req_ready", {31'h0, req_ready}, 32'h1);
      chk("idle mem_is_load", {31'h0, mem_is_load}, 32'h0);

      for (int i = 0; i < 26; i++) begin
         run_req(vt[i], i);
      end

      // Memory unaffected by the error requests
      chk("mem 0x40 after errors", mem[8'h10], 32'hCAFE12EF);

      // SB to 0x44 with reset asserted during its WRITE cycle
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h44;
      req_wdata  = 32'h77;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      @(negedge clk);
      chk("rstw rmw_rd load", {31'h0, mem_is_load}, 32'h1);
      chk("rstw rmw_rd resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
      chk("rstw write store", {31'h0, mem_is_store}, 32'h1);
      chk("rstw write data", mem_store_data, 32'h9923BE77);
      rst_n = 1'b0;
      #1;
      chk("rstw store gated", {31'h0, mem_is_store}, 32'h0);
      @(negedge clk);
      chk("rstw no resp", {31'h0, resp_valid}, 32'h0);
      chk("rstw ready in reset", {31'h0, req_ready}, 32'h0);
      chk("rstw mem unchanged", mem[8'h11], 32'h9923BEEF);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstw ready after", {31'h0, req_ready}, 32'h1);
      chk("rstw no resp after", {31'h0, resp_valid}, 32'h0);
      run_req(mk(1'b0, 3'b010, 32'h44, 32'h0, 32'h9923BEEF, 1'b0, 2, 1, 0, 32'h0), 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
